// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types for the fetch front-end (word, queued fetch entry, FSM states)
package fetch_unit_pkg;
  typedef logic [31:0] word_t;
  typedef struct packed {
    word_t instr;
    word_t pc;
  } fetch_entry_t;
  typedef enum logic [1:0] {IDLE, REQ, KILL} fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem, redirect and dispatch signals of the fetch stage
interface fetch_unit_if;
  import fetch_unit_pkg::*;
  logic  iren;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  word_t pc_prediction;
  logic  misprediction;
  logic  flush;
  word_t correct_target;
  logic  stall;
  logic  dispatch_free;
  logic  instr_valid;
  word_t instr;
  word_t pc;
  modport master (
    output iren, imemaddr, instr_valid, instr, pc,
    input  ihit, imemload, pc_prediction, misprediction, flush, correct_target, stall, dispatch_free
  );
  modport slave (
    input  iren, imemaddr, instr_valid, instr, pc,
    output ihit, imemload, pc_prediction, misprediction, flush, correct_target, stall, dispatch_free
  );
endinterface

// File: rtl/fetch_unit_queue.sv
// fetch_unit_queue: DEPTH-entry circular FIFO of fetch entries with push/pop/clear
module fetch_unit_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_clear,
  input  fetch_entry_t               i_din,
  output fetch_entry_t               o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  fetch_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + AW'(1);
      if (i_pop) r_head <= r_head + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end
  always_ff @(posedge CLK)
    if (i_push && !i_clear) r_mem[r_tail] <= i_din;
  assign o_empty = r_count == '0;
  assign o_full  = r_count == CW'(DEPTH);
  assign o_count = r_count;
  assign o_dout  = o_empty ? '0 : r_mem[r_head];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: request FSM, next-PC/redirect handling and fetch queue feeding dispatch.
// Define FETCH_PERF_EN to add saturating fetched/squashed perf counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int    DEPTH    = 4,
  parameter word_t RESET_PC = '0
`ifdef FETCH_PERF_EN
  , parameter int  CNT_W    = 32
`endif
) (
  input  logic              CLK,
  input  logic              nRST,
  fetch_unit_if.master      bus
`ifdef FETCH_PERF_EN
  , output logic [CNT_W-1:0] o_fetched_cnt
  , output logic [CNT_W-1:0] o_squash_cnt
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_t  r_state;
  word_t         r_next_pc, r_imemaddr;
  logic          w_redirect, w_push, w_pop, w_full, w_empty;
  logic [CW-1:0] w_count, w_count_after;
  fetch_entry_t  w_din, w_head;
  assign w_redirect    = bus.misprediction | bus.flush;
  assign w_push        = (r_state == REQ) & bus.ihit & !w_redirect;
  assign w_pop         = bus.instr_valid & bus.dispatch_free & !w_redirect;
  assign w_count_after = w_count + CW'(w_push) - CW'(w_pop);
  assign w_din         = {bus.imemload, r_imemaddr};
  assign bus.iren        = r_state != IDLE;
  assign bus.imemaddr    = r_imemaddr;
  assign bus.instr_valid = !w_empty & !bus.stall;
  assign bus.instr       = w_head.instr;
  assign bus.pc          = w_head.pc;
  fetch_unit_queue #(.DEPTH(DEPTH)) u_queue (
    .CLK     (CLK),
    .nRST    (nRST),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (w_redirect),
    .i_din   (w_din),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );
  // queue slot is reserved when a request starts, so a push on ihit always fits
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_next_pc  <= RESET_PC;
      r_imemaddr <= '0;
    end else begin
      if (w_redirect) r_next_pc <= bus.correct_target;
      case (r_state)
        IDLE: if (!w_redirect && !bus.stall && !w_full) begin
          r_state    <= REQ;
          r_imemaddr <= r_next_pc;
        end
        REQ: if (w_redirect) r_state <= bus.ihit ? IDLE : KILL;
        else if (bus.ihit) begin
          r_next_pc <= bus.pc_prediction;
          if (!bus.stall && w_count_after < CW'(DEPTH)) r_imemaddr <= bus.pc_prediction;
          else r_state <= IDLE;
        end
        KILL: if (bus.ihit) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef FETCH_PERF_EN
  logic [CNT_W-1:0] r_fetched, r_squash;
  logic [CNT_W:0]   w_sq_sum;
  assign w_sq_sum = {1'b0, r_squash} + (CNT_W+1)'(w_count) + (CNT_W+1)'(r_state == REQ);
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_fetched <= '0;
      r_squash  <= '0;
    end else begin
      if (w_push && !(&r_fetched)) r_fetched <= r_fetched + CNT_W'(1);
      if (w_redirect) r_squash <= w_sq_sum[CNT_W] ? '1 : w_sq_sum[CNT_W-1:0];
    end
  end
  assign o_fetched_cnt = r_fetched;
  assign o_squash_cnt  = r_squash;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven, directed and randomized checks of fetch_unit against a queue-based model
module tb_fetch_unit;
  import fetch_unit_pkg::*;
  localparam int DEPTH = 4;
  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;
  fetch_unit_if bus();
`ifdef FETCH_PERF_EN
  logic [31:0] fetched_cnt, squash_cnt;
`endif
  fetch_unit #(.DEPTH(DEPTH)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
`ifdef FETCH_PERF_EN
    , .o_fetched_cnt (fetched_cnt)
    , .o_squash_cnt  (squash_cnt)
`endif
  );
  int errors = 0;
  int checks = 0;
  bit m_busy, m_kill;
  word_t m_addr, m_npc;
  fetch_entry_t mq[$];
  int m_fetched, m_squash;
  typedef struct {
    bit    ih, st, df, e_iren;
    word_t e_addr;
    bit    e_valid;
    word_t e_pc;
  } vec_t;
  vec_t tbl[12];
  function automatic word_t enc(word_t a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_check();
    bit v;
    v = mq.size() > 0 && !bus.stall;
    chk("iren", 32'(bus.iren), 32'(m_busy));
    if (m_busy) chk("imemaddr", bus.imemaddr, m_addr);
    chk("instr_valid", 32'(bus.instr_valid), 32'(v));
    if (v) begin
      chk("pc", bus.pc, mq[0].pc);
      chk("instr", bus.instr, mq[0].instr);
    end
  endtask
  task automatic model_update();
    bit redir, ih, pop;
    int sz;
    redir = bus.misprediction | bus.flush;
    ih    = bus.ihit;
    sz    = mq.size();
    pop   = sz > 0 && !bus.stall && bus.dispatch_free;
    if (redir) begin
      m_squash += sz + int'(m_busy && !m_kill);
      mq.delete();
      m_npc = bus.correct_target;
      if (m_busy) begin
        if (ih) begin m_busy = 0; m_kill = 0; end
        else m_kill = 1;
      end
    end else if (m_busy && ih) begin
      if (!m_kill) begin
        mq.push_back('{instr: bus.imemload, pc: m_addr});
        m_fetched++;
        m_npc = bus.pc_prediction;
      end
      if (pop) void'(mq.pop_front());
      if (!m_kill && !bus.stall && mq.size() < DEPTH) m_addr = bus.pc_prediction;
      else m_busy = 0;
      m_kill = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (!m_busy && !bus.stall && sz < DEPTH) begin m_busy = 1; m_addr = m_npc; end
    end
  endtask
  task automatic drive(bit ih, bit mis, bit fl, bit st, bit df, word_t tgt = '0, bit jump = 0);
    @(negedge CLK);
    bus.ihit           = ih & bus.iren;
    bus.misprediction  = mis;
    bus.flush          = fl;
    bus.stall          = st;
    bus.dispatch_free  = df;
    bus.correct_target = tgt;
    bus.imemload       = enc(bus.imemaddr);
    bus.pc_prediction  = jump ? word_t'($urandom_range(0, 1023)) << 2 : bus.imemaddr + 32'd4;
    #1 model_check();
  endtask
  task automatic finish_cycle();
    @(posedge CLK);
    model_update();
  endtask
  task automatic step(bit ih, bit mis, bit fl, bit st, bit df, word_t tgt = '0, bit jump = 0);
    drive(ih, mis, fl, st, df, tgt, jump);
    finish_cycle();
  endtask
  task automatic do_reset();
    nRST = 1'b0;
    bus.ihit = 0; bus.misprediction = 0; bus.flush = 0; bus.stall = 0; bus.dispatch_free = 0;
    bus.correct_target = '0; bus.imemload = '0; bus.pc_prediction = '0;
    m_busy = 0; m_kill = 0; m_addr = '0; m_npc = '0; mq.delete(); m_fetched = 0; m_squash = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset iren", 32'(bus.iren), 32'd0);
    chk("reset instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("reset imemaddr", bus.imemaddr, 32'd0);
    nRST = 1'b1;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    tbl[0]  = '{1, 0, 0, 0, 0,  0, 0};
    tbl[1]  = '{1, 0, 0, 1, 0,  0, 0};
    tbl[2]  = '{1, 0, 0, 1, 4,  1, 0};
    tbl[3]  = '{1, 0, 0, 1, 8,  1, 0};
    tbl[4]  = '{1, 0, 0, 1, 12, 1, 0};
    tbl[5]  = '{1, 0, 0, 0, 0,  1, 0};
    tbl[6]  = '{1, 0, 1, 0, 0,  1, 0};
    tbl[7]  = '{1, 0, 1, 0, 0,  1, 4};
    tbl[8]  = '{1, 0, 1, 1, 16, 1, 8};
    tbl[9]  = '{1, 0, 1, 1, 20, 1, 12};
    tbl[10] = '{1, 0, 1, 1, 24, 1, 16};
    tbl[11] = '{1, 0, 1, 1, 28, 1, 20};
    // streaming fetch, fill to DEPTH with dispatch blocked, then drain in order
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].ih, 0, 0, tbl[i].st, tbl[i].df);
      chk($sformatf("tbl%0d iren", i), 32'(bus.iren), 32'(tbl[i].e_iren));
      if (tbl[i].e_iren) chk($sformatf("tbl%0d imemaddr", i), bus.imemaddr, tbl[i].e_addr);
      chk($sformatf("tbl%0d valid", i), 32'(bus.instr_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d pc", i), bus.pc, tbl[i].e_pc);
        chk($sformatf("tbl%0d instr", i), bus.instr, enc(tbl[i].e_pc));
      end
      finish_cycle();
    end
    // misprediction with request outstanding: late ihit is discarded
    do_reset();
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1, 32'h100);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 1);
    chk("kill iren", 32'(bus.iren), 32'd1);
    finish_cycle();
    drive(1, 0, 0, 0, 1);
    chk("kill valid", 32'(bus.instr_valid), 32'd0);
    finish_cycle();
    drive(0, 0, 0, 0, 1);
    chk("redirect imemaddr", bus.imemaddr, 32'h100);
    chk("redirect iren", 32'(bus.iren), 32'd1);
    finish_cycle();
    // flush coinciding with pop and ihit
    do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 1, 32'h200);
    chk("flush pre pc", bus.pc, 32'd0);
    finish_cycle();
    drive(0, 0, 0, 0, 1);
    chk("flush valid", 32'(bus.instr_valid), 32'd0);
    finish_cycle();
    drive(0, 0, 0, 0, 1);
    chk("flush target", bus.imemaddr, 32'h200);
    finish_cycle();
    // stall with entries queued and a fetch in flight
    do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1);
    chk("stall valid", 32'(bus.instr_valid), 32'd0);
    chk("stall inflight iren", 32'(bus.iren), 32'd1);
    finish_cycle();
    step(1, 0, 0, 1, 1);
    drive(1, 0, 0, 1, 1);
    chk("stall no iren", 32'(bus.iren), 32'd0);
    finish_cycle();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1);
      chk($sformatf("stall order%0d", i), bus.pc, 32'(4 * i));
      finish_cycle();
    end
`ifdef FETCH_PERF_EN
    do_reset();
    for (int n = 0; m_fetched < 8; n++) begin
      if (n > 100) begin chk("perf phase1 budget", 32'(m_fetched), 32'd8); break; end
      step(1, 0, 0, 0, 1);
    end
    for (int n = 0; m_fetched < 10; n++) begin
      if (n > 100) begin chk("perf phase2 budget", 32'(m_fetched), 32'd10); break; end
      step(1, 0, 0, 0, 0);
    end
    step(0, 1, 0, 0, 0, 32'h40);
    drive(0, 0, 0, 0, 0);
    chk("fetched_cnt", fetched_cnt, 32'd10);
    chk("squash_cnt", squash_cnt, 32'd4);
    finish_cycle();
`endif
    do_reset();
    for (int i = 0; i < 3000; i++)
      step($urandom % 3 != 0, $urandom % 23 == 0, $urandom % 41 == 0, $urandom % 7 == 0,
           $urandom % 4 != 0, word_t'($urandom_range(0, 4095)) << 2, $urandom % 5 == 0);
`ifdef FETCH_PERF_EN
    drive(0, 0, 0, 0, 0);
    chk("rand fetched_cnt", fetched_cnt, 32'(m_fetched));
    chk("rand squash_cnt", squash_cnt, 32'(m_squash));
    finish_cycle();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
